ddr2_wr_sequencer: RTL and testbench

Write-path sequencer for the DDR2 data-path IOB bank. It turns a one-cycle WRITE-command pulse from the command scheduler into correctly timed DQS preamble/enable, DQ write-enable, DM write-enable and write-FIFO data-request strobes. It honours the programmed write latency and burst length, and supports seamless back-to-back bursts. It sits between the controller's command FSM and the data-path IOB wrapper, driving that wrapper's `dqs_rst`, `dqs_en`, `wr_en[1:0]` and `dm_wr_en` inputs.

---
 rtl/ddr2_wr_sequencer_if.sv | 47 ++++
 rtl/ddr2_wr_sequencer.sv | 148 ++++++++++++++
 tb/tb_ddr2_wr_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ddr2_wr_sequencer_if.sv
// Bundle between the command scheduler / IOB wrapper and the write-path sequencer.
// Latency: none, plain wires.
// Backpressure: none; the command side is a one-cycle pulse, the rest are strobes.
//
// Signals:
//   wr_cmd      one-cycle WRITE issue pulse from the command scheduler
//   wr_data_req write-data FIFO pop request, one cycle ahead of data
//   dqs_rst     holds DQS low for the preamble
//   dqs_en      DQS output enable (preamble + data + postamble)
//   wr_en       DQ output enable, both bits identical
//   dm_wr_en    DM output enable
//   busy        a burst is pending or in flight
//   cmd_err     one-cycle pulse when wr_cmd is dropped
interface ddr2_wr_sequencer_if;
    logic       wr_cmd;
    logic       wr_data_req;
    logic       dqs_rst;
    logic       dqs_en;
    logic [1:0] wr_en;
    logic       dm_wr_en;
    logic       busy;
    logic       cmd_err;

    // Scheduler / wrapper side.
    modport master (
        output wr_cmd,
        input  wr_data_req,
        input  dqs_rst,
        input  dqs_en,
        input  wr_en,
        input  dm_wr_en,
        input  busy,
        input  cmd_err
    );

    // Sequencer side.
    modport slave (
        input  wr_cmd,
        output wr_data_req,
        output dqs_rst,
        output dqs_en,
        output wr_en,
        output dm_wr_en,
        output busy,
        output cmd_err
    );
endinterface

// File: rtl/ddr2_wr_sequencer.sv
// DDR2 write-path sequencer: WRITE pulse -> DQS preamble/enable, DQ/DM enables, FIFO pop requests.
// Latency: first wr_en exactly WRITE_LATENCY cycles after wr_cmd; wr_data_req leads wr_en by one cycle.
// Backpressure: none; a wr_cmd closer than BURST_LEN/2 cycles to the last accepted one is dropped and flagged on cmd_err.
//
// Ports:
//   clk       controller clock, rising edge only
//   reset0_n  asynchronous active-low reset, clears all pending bursts and outputs
//   bus       slave side of ddr2_wr_sequencer_if (wr_cmd in; strobes, busy, cmd_err out)
// All outputs are registered.
module ddr2_wr_sequencer #(
    parameter int WRITE_LATENCY = 4,
    parameter int BURST_LEN     = 4,
    parameter int USE_DM_PORT   = 1
) (
    input  logic               clk,
    input  logic               reset0_n,
    ddr2_wr_sequencer_if.slave bus
);

    localparam int NB = BURST_LEN / 2;      // data cycles per burst
    localparam int WL = WRITE_LATENCY;
    localparam int CW = $clog2(NB + 2);     // wide enough for the longest (DQS) window count

    if (BURST_LEN != 4 && BURST_LEN != 8) begin : g_bad_burst_len
        $error("ddr2_wr_sequencer: BURST_LEN must be 4 or 8");
    end
    if (WRITE_LATENCY < 2 || WRITE_LATENCY > 10) begin : g_bad_write_latency
        $error("ddr2_wr_sequencer: WRITE_LATENCY must be within 2..10");
    end

    // Command-delay line. Bit i is high in cycle c+i for a command accepted at
    // edge c, so the top bit (c+WL-2) is the cycle before the first strobe,
    // which is when the window registers must be loaded.
    logic [WL-2:0] pipe, pipe_next;

    logic [CW-1:0] space_cnt, space_cnt_next;   // cycles left before another command may be accepted
    logic [CW-1:0] req_cnt,   req_cnt_next;     // remaining wr_data_req cycles after the current one
    logic [CW-1:0] dqs_cnt,   dqs_cnt_next;     // remaining dqs_en cycles after the current one

    logic       req_q,   req_next;
    logic       rst_q,   rst_next;
    logic       dqs_q,   dqs_next;
    logic [1:0] wr_en_q, wr_en_next;
    logic       dm_q,    dm_next;
    logic       busy_q,  busy_next;
    logic       err_q,   err_next;

    logic accept;
    logic trig;

    assign accept = bus.wr_cmd && (space_cnt == '0);
    assign trig   = pipe[WL-2];

    always_comb begin
        pipe_next      = '0;
        space_cnt_next = space_cnt;
        req_cnt_next   = req_cnt;
        dqs_cnt_next   = dqs_cnt;
        req_next       = 1'b0;
        rst_next       = 1'b0;
        dqs_next       = 1'b0;
        wr_en_next     = 2'b00;
        dm_next        = 1'b0;
        busy_next      = 1'b0;
        err_next       = 1'b0;

        pipe_next[0] = accept;
        for (int i = 1; i < WL - 1; i++) begin
            pipe_next[i] = pipe[i-1];
        end

        // Only an accepted command restarts the spacing window; a dropped one
        // must not push the next legal slot further out.
        if (accept) begin
            space_cnt_next = CW'(NB - 1);
        end else if (space_cnt != '0) begin
            space_cnt_next = space_cnt - CW'(1);
        end
        err_next = bus.wr_cmd && !accept;

        // Command spacing guarantees request windows never overlap, so a
        // reload simply starts the next burst's window.
        if (trig) begin
            req_cnt_next = CW'(NB - 1);
            req_next     = 1'b1;
        end else if (req_cnt != '0) begin
            req_cnt_next = req_cnt - CW'(1);
            req_next     = 1'b1;
        end

        // DQS windows (NB+2 long) can overlap; reloading always extends the
        // window to the later burst's end, which gives the OR-merge.
        if (trig) begin
            dqs_cnt_next = CW'(NB + 1);
            dqs_next     = 1'b1;
        end else if (dqs_cnt != '0) begin
            dqs_cnt_next = dqs_cnt - CW'(1);
            dqs_next     = 1'b1;
        end

        // Preamble only when DQS is currently idle; a burst that continues an
        // active DQS window is seamless.
        rst_next = trig && !dqs_q;

        // DQ/DM enables trail the FIFO request by exactly one cycle.
        wr_en_next = {2{req_q}};
        dm_next    = (USE_DM_PORT != 0) && req_q;

        busy_next = (|pipe_next) || dqs_next;
    end

    always_ff @(posedge clk or negedge reset0_n) begin
        if (!reset0_n) begin
            pipe      <= '0;
            space_cnt <= '0;
            req_cnt   <= '0;
            dqs_cnt   <= '0;
            req_q     <= 1'b0;
            rst_q     <= 1'b0;
            dqs_q     <= 1'b0;
            wr_en_q   <= 2'b00;
            dm_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pipe      <= pipe_next;
            space_cnt <= space_cnt_next;
            req_cnt   <= req_cnt_next;
            dqs_cnt   <= dqs_cnt_next;
            req_q     <= req_next;
            rst_q     <= rst_next;
            dqs_q     <= dqs_next;
            wr_en_q   <= wr_en_next;
            dm_q      <= dm_next;
            busy_q    <= busy_next;
            err_q     <= err_next;
        end
    end

    assign bus.wr_data_req = req_q;
    assign bus.dqs_rst     = rst_q;
    assign bus.dqs_en      = dqs_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.dm_wr_en    = dm_q;
    assign bus.busy        = busy_q;
    assign bus.cmd_err     = err_q;

endmodule

// File: tb/tb_ddr2_wr_sequencer.sv
// Testbench for ddr2_wr_sequencer: two instances (WL=4/BL=4/DM on, WL=2/BL=8/DM off).
// Latency: n/a.
// Backpressure: n/a.
module tb_ddr2_wr_sequencer;

    logic clk = 1'b0;
    logic reset0_n;

    always #5 clk = ~clk;

    ddr2_wr_sequencer_if a_if ();
    ddr2_wr_sequencer_if b_if ();

    ddr2_wr_sequencer #(
        .WRITE_LATENCY(4),
        .BURST_LEN    (4),
        .USE_DM_PORT  (1)
    ) dut_a (
        .clk     (clk),
        .reset0_n(reset0_n),
        .bus     (a_if)
    );

    ddr2_wr_sequencer #(
        .WRITE_LATENCY(2),
        .BURST_LEN    (8),
        .USE_DM_PORT  (0)
    ) dut_b (
        .clk     (clk),
        .reset0_n(reset0_n),
        .bus     (b_if)
    );

    // One scenario: per-signal 16-cycle masks, bit k = cycle k after edge k.
    typedef struct packed {
        logic [15:0] cmd;
        logic [15:0] req;
        logic [15:0] rst;
        logic [15:0] dqs;
        logic [15:0] wr;
        logic [15:0] dm;
        logic [15:0] busy;
        logic [15:0] err;
    } scn_t;

    int checks   = 0;
    int failures = 0;

    scn_t a_tbl [7];
    scn_t b_tbl [2];

    function automatic logic [15:0] rng(input int lo, input int hi);
        logic [15:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Packed view: {wr_data_req, dqs_rst, dqs_en, wr_en[1:0], dm_wr_en, busy, cmd_err}
    function automatic logic [7:0] act_vec(input int sel);
        if (sel == 0)
            return {a_if.wr_data_req, a_if.dqs_rst, a_if.dqs_en, a_if.wr_en,
                    a_if.dm_wr_en, a_if.busy, a_if.cmd_err};
        else
            return {b_if.wr_data_req, b_if.dqs_rst, b_if.dqs_en, b_if.wr_en,
                    b_if.dm_wr_en, b_if.busy, b_if.cmd_err};
    endfunction

    function automatic logic [7:0] exp_vec(input scn_t s, input int k);
        return {s.req[k], s.rst[k], s.dqs[k], s.wr[k], s.wr[k], s.dm[k], s.busy[k], s.err[k]};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b (req,rst,dqs_en,wr_en[2],dm,busy,err)",
                     nm, act, exp);
        end
    endtask

    // Must be entered between a rising edge and the next one (normally at a
    // falling edge); leaves at the falling edge of the last cycle checked.
    task automatic run_scn(input int sel, input scn_t s, input int id, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (sel == 0) a_if.wr_cmd = s.cmd[k];
            else          b_if.wr_cmd = s.cmd[k];
            @(posedge clk);
            #1;
            check($sformatf("%s%0d_cyc%0d", (sel == 0) ? "A" : "B", id, k),
                  act_vec(sel), exp_vec(s, k));
            @(negedge clk);
        end
        a_if.wr_cmd = 1'b0;
        b_if.wr_cmd = 1'b0;
    endtask

    initial begin
        // WL=4, BL=4 (NB=2), DM enabled.
        // 0: single write at 0
        a_tbl[0] = '{cmd: rng(0,0), req: rng(3,4), rst: rng(3,3), dqs: rng(3,6),
                     wr: rng(4,5), dm: rng(4,5), busy: rng(0,6), err: 16'h0};
        // 1: seamless, commands at 0 and 2
        a_tbl[1] = '{cmd: rng(0,0) | rng(2,2), req: rng(3,6), rst: rng(3,3), dqs: rng(3,8),
                     wr: rng(4,7), dm: rng(4,7), busy: rng(0,8), err: 16'h0};
        // 2: spacing violation, commands at 0 and 1 (second dropped)
        a_tbl[2] = '{cmd: rng(0,1), req: rng(3,4), rst: rng(3,3), dqs: rng(3,6),
                     wr: rng(4,5), dm: rng(4,5), busy: rng(0,6), err: rng(1,1)};
        // 3: commands at 0,1,2: 1 dropped, 2 accepted (drop does not restart spacing)
        a_tbl[3] = '{cmd: rng(0,2), req: rng(3,6), rst: rng(3,3), dqs: rng(3,8),
                     wr: rng(4,7), dm: rng(4,7), busy: rng(0,8), err: rng(1,1)};
        // 4: gapped by 4: windows touch, DQS merged
        a_tbl[4] = '{cmd: rng(0,0) | rng(4,4), req: rng(3,4) | rng(7,8), rst: rng(3,3),
                     dqs: rng(3,10), wr: rng(4,5) | rng(8,9), dm: rng(4,5) | rng(8,9),
                     busy: rng(0,10), err: 16'h0};
        // 5: gapped by 5: DQS gap, second preamble
        a_tbl[5] = '{cmd: rng(0,0) | rng(5,5), req: rng(3,4) | rng(8,9), rst: rng(3,3) | rng(8,8),
                     dqs: rng(3,6) | rng(8,11), wr: rng(4,5) | rng(9,10), dm: rng(4,5) | rng(9,10),
                     busy: rng(0,11), err: 16'h0};
        // 6: commands at 0,1,3: 1 dropped, 3 accepted into an overlapping DQS window
        a_tbl[6] = '{cmd: rng(0,1) | rng(3,3), req: rng(3,4) | rng(6,7), rst: rng(3,3),
                     dqs: rng(3,9), wr: rng(4,5) | rng(7,8), dm: rng(4,5) | rng(7,8),
                     busy: rng(0,9), err: rng(1,1)};

        // WL=2, BL=8 (NB=4), DM disabled.
        // 0: single write at 0
        b_tbl[0] = '{cmd: rng(0,0), req: rng(1,4), rst: rng(1,1), dqs: rng(1,6),
                     wr: rng(2,5), dm: 16'h0, busy: rng(0,6), err: 16'h0};
        // 1: commands at 0,3,4: 3 dropped (spacing 4), 4 seamless
        b_tbl[1] = '{cmd: rng(0,0) | rng(3,4), req: rng(1,8), rst: rng(1,1), dqs: rng(1,10),
                     wr: rng(2,9), dm: 16'h0, busy: rng(0,10), err: rng(3,3)};

        a_if.wr_cmd = 1'b0;
        b_if.wr_cmd = 1'b0;
        reset0_n    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state_A", act_vec(0), 8'h00);
        check("reset_state_B", act_vec(1), 8'h00);

        // Release at a falling edge; the first scenario's command lands on the
        // very first rising edge after deassertion.
        @(negedge clk);
        reset0_n = 1'b1;

        for (int i = 0; i < 7; i++) run_scn(0, a_tbl[i], i, 16);
        for (int i = 0; i < 2; i++) run_scn(1, b_tbl[i], i, 16);

        // Reset mid-burst: single write at 0, reset dropped during cycle 4.
        run_scn(0, a_tbl[0], 100, 5);
        reset0_n = 1'b0;
        #1;
        check("midburst_async_clear_A", act_vec(0), 8'h00);
        check("midburst_async_clear_B", act_vec(1), 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset0_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset_quiet_cyc%0d", k), act_vec(0), 8'h00);
            @(negedge clk);
        end
        // Fresh single write after release, relative to its own cycle.
        run_scn(0, a_tbl[0], 101, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
